// File: rtl/lcd_pixel_fifo_if.sv
// Pixel output stream of lcd_pixel_fifo: show-ahead head entry plus a valid/ready handshake.
// A word moves on every clock where o_valid and i_ready are both high; while o_valid is high
// and i_ready is low, o_data/o_sof hold the same head entry.
interface lcd_pixel_fifo_if;
  logic [15:0] o_data;
  logic        o_sof;
  logic        o_valid;
  logic        i_ready;

  modport master (output o_data, output o_sof, output o_valid, input i_ready);
  modport slave  (input o_data, input o_sof, input o_valid, output i_ready);
endinterface

// File: rtl/lcd_pixel_fifo.sv
// VGA-timed RGB888 to RGB565 pixel FIFO with frame geometry check and overflow frame drop.
// Optional 2x2 ordered dither before truncation: define LCD_PIXEL_FIFO_DITHER_EN.
module lcd_pixel_fifo #(
  parameter int c_x_size    = 240,
  parameter int c_y_size    = 240,
  parameter int c_fifo_bits = 6
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic                 clk_pixel_ena,
  input  logic                 blank,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic [7:0]           i_r,
  input  logic [7:0]           i_g,
  input  logic [7:0]           i_b,
  lcd_pixel_fifo_if.master     io_stream,
  output logic [c_fifo_bits:0] o_level,
  output logic                 o_overflow,
  output logic                 o_frame_err
);
  localparam int c_depth    = 1 << c_fifo_bits;
  localparam int c_xy_max   = (c_x_size > c_y_size) ? c_x_size : c_y_size;
  localparam int c_cnt_bits = $clog2(c_xy_max + 1) + 1;
  localparam logic [c_cnt_bits-1:0]  c_cnt_max    = '1;
  localparam logic [c_cnt_bits-1:0]  c_x_exp      = c_cnt_bits'(c_x_size);
  localparam logic [c_cnt_bits-1:0]  c_y_exp      = c_cnt_bits'(c_y_size);
  localparam logic [c_fifo_bits:0]   c_level_full = {1'b1, {c_fifo_bits{1'b0}}};

  logic r_prev_vsync, r_prev_blank, r_vs_seen, r_sof_pend, r_drop;
  logic r_frame_err, r_overflow;
  logic [c_cnt_bits-1:0] r_x, r_y;
  logic r_s1_valid, r_s1_sof;

  logic w_vs_rise, w_bl_rise, w_active;
  logic w_push_valid, w_push_sof;
  logic [15:0] w_push_data;
  logic w_valid, w_full, w_pop, w_push, w_overflow, w_write;
  logic [16:0] w_head;
  logic w_unused;

  logic [16:0]            r_mem [c_depth];
  logic [c_fifo_bits-1:0] r_wptr, r_rptr;
  logic [c_fifo_bits:0]   r_level;

  assign w_vs_rise = clk_pixel_ena & vsync & ~r_prev_vsync;
  assign w_bl_rise = clk_pixel_ena & blank & ~r_prev_blank;
  assign w_active  = clk_pixel_ena & ~blank;

  // prev_blank starts high so a blanked input after reset is not seen as a line end
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_prev_vsync <= 1'b0;
      r_prev_blank <= 1'b1;
      r_vs_seen    <= 1'b0;
      r_sof_pend   <= 1'b0;
      r_drop       <= 1'b1;
      r_frame_err  <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
    end else begin
      r_frame_err <= 1'b0;
      if (clk_pixel_ena) begin
        r_prev_vsync <= vsync;
        r_prev_blank <= blank;
      end
      if (w_vs_rise) begin
        r_sof_pend <= 1'b1;
        r_vs_seen  <= 1'b1;
        r_x        <= '0;
        r_y        <= '0;
        if (r_vs_seen && (r_y != c_y_exp)) r_frame_err <= 1'b1;
      end else if (w_active) begin
        if (r_x != c_cnt_max) r_x <= r_x + 1'b1;
        if (!r_drop) r_sof_pend <= 1'b0;
      end else if (w_bl_rise) begin
        if (r_x != c_x_exp) r_frame_err <= 1'b1;
        r_x <= '0;
        if (r_y != c_cnt_max) r_y <= r_y + 1'b1;
      end
      // a new frame always re-arms, even if a stale pixel overflows in the same cycle
      if (w_vs_rise)       r_drop <= 1'b0;
      else if (w_overflow) r_drop <= 1'b1;
    end
  end

`ifdef LCD_PIXEL_FIFO_DITHER_EN
  logic [7:0]  r_s1_r, r_s1_g, r_s1_b;
  logic [1:0]  r_s1_yx;
  logic        r_s2_valid, r_s2_sof;
  logic [15:0] r_s2_data;
  logic [7:0]  w_d_r, w_d_g, w_d_b;

  function automatic logic [2:0] f_off_rb(input logic [1:0] yx);
    case (yx)
      2'b00:   f_off_rb = 3'd0;
      2'b01:   f_off_rb = 3'd4;
      2'b10:   f_off_rb = 3'd6;
      default: f_off_rb = 3'd2;
    endcase
  endfunction

  function automatic logic [2:0] f_off_g(input logic [1:0] yx);
    case (yx)
      2'b00:   f_off_g = 3'd0;
      2'b01:   f_off_g = 3'd2;
      2'b10:   f_off_g = 3'd3;
      default: f_off_g = 3'd1;
    endcase
  endfunction

  function automatic logic [7:0] f_sat_add(input logic [7:0] a, input logic [2:0] off);
    logic [8:0] s;
    s = {1'b0, a} + {6'd0, off};
    f_sat_add = s[8] ? 8'hFF : s[7:0];
  endfunction

  assign w_d_r = f_sat_add(r_s1_r, f_off_rb(r_s1_yx));
  assign w_d_g = f_sat_add(r_s1_g, f_off_g(r_s1_yx));
  assign w_d_b = f_sat_add(r_s1_b, f_off_rb(r_s1_yx));

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_r     <= '0;
      r_s1_g     <= '0;
      r_s1_b     <= '0;
      r_s1_yx    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_sof   <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      r_s1_valid <= w_active & ~r_drop;
      r_s1_sof   <= r_sof_pend;
      r_s1_r     <= i_r;
      r_s1_g     <= i_g;
      r_s1_b     <= i_b;
      r_s1_yx    <= {r_y[0], r_x[0]};
      r_s2_valid <= r_s1_valid;
      r_s2_sof   <= r_s1_sof;
      r_s2_data  <= {w_d_r[7:3], w_d_g[7:2], w_d_b[7:3]};
    end
  end

  assign w_push_valid = r_s2_valid;
  assign w_push_sof   = r_s2_sof;
  assign w_push_data  = r_s2_data;
  assign w_unused     = &{1'b0, hsync, w_d_r[2:0], w_d_g[1:0], w_d_b[2:0]};
`else
  logic [15:0] r_s1_data;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_active & ~r_drop;
      r_s1_sof   <= r_sof_pend;
      r_s1_data  <= {i_r[7:3], i_g[7:2], i_b[7:3]};
    end
  end

  assign w_push_valid = r_s1_valid;
  assign w_push_sof   = r_s1_sof;
  assign w_push_data  = r_s1_data;
  assign w_unused     = &{1'b0, hsync, i_r[2:0], i_g[1:0], i_b[2:0]};
`endif

  // pixels already in flight when an overflow hits are discarded with the rest of the frame
  assign w_push     = w_push_valid & ~r_drop;
  assign w_valid    = (r_level != '0);
  assign w_full     = (r_level == c_level_full);
  assign w_pop      = w_valid & io_stream.i_ready;
  assign w_overflow = w_push & w_full & ~w_pop;
  assign w_write    = w_push & ~w_overflow;

  always_ff @(posedge clk_pixel) begin
    if (w_write) r_mem[r_wptr] <= {w_push_sof, w_push_data};
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_write) r_wptr <= r_wptr + 1'b1;
      if (w_pop)   r_rptr <= r_rptr + 1'b1;
      if (w_write && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_write && w_pop) r_level <= r_level - 1'b1;
      if (w_overflow) r_overflow <= 1'b1;
    end
  end

  assign w_head            = r_mem[r_rptr];
  assign io_stream.o_valid = w_valid;
  assign io_stream.o_data  = w_valid ? w_head[15:0] : 16'h0000;
  assign io_stream.o_sof   = w_valid ? w_head[16] : 1'b0;
  assign o_level           = r_level;
  assign o_overflow        = r_overflow;
  assign o_frame_err       = r_frame_err;
endmodule
